// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the regfile write arbiter:
// state encoding, index/data widths, external window defaults, queued request payload.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ENTRY_W    = REG_W + DATA_W;
  localparam int unsigned EXT_LO_DEF = 26;
  localparam int unsigned EXT_HI_DEF = 29;

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    FORCE_EXT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // True when a register index lies inside the externally writable window.
  function automatic logic in_window(input logic [REG_W-1:0] idx,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(idx) >= lo) && (32'(idx) <= hi);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback, external-request and regfile-write signals of the arbiter.
// The master side is the requester/regfile environment; the slave side is the arbiter.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic              wb_we;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;

  logic              ext_valid;
  logic [REG_W-1:0]  ext_reg;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ready;
  logic              ext_err;

  logic              rf_we;
  logic [REG_W-1:0]  rf_reg;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output wb_we, wb_reg, wb_data, ext_valid, ext_reg, ext_data,
    input  wb_stall, ext_ready, ext_err, rf_we, rf_reg, rf_data
  );

  modport slave (
    input  wb_we, wb_reg, wb_data, ext_valid, ext_reg, ext_data,
    output wb_stall, ext_ready, ext_err, rf_we, rf_reg, rf_data
  );

endinterface

// File: rtl/regfile_write_arbiter_wr_req_fifo.sv
// Power-of-two deep FIFO of pending external register writes.
// Also exposes next-cycle fullness so the owner can register its ready flag.
module wr_req_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clock,
  input  logic    ctrl_reset,
  input  logic    i_push,
  input  wr_req_t i_entry,
  input  logic    i_pop,
  output wr_req_t o_head_c,
  output logic    o_full,
  output logic    o_empty,
  output logic    o_full_next_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Pointers wrap through natural overflow since DEPTH is a power of two.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head_c      = r_mem[r_rd_ptr];
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_full_next_c = (w_count_next == CNT_W'(DEPTH));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates pipeline writebacks and buffered external writes onto the single
// regfile write port; writeback has priority until a starved external write is forced.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned EXT_LO       = EXT_LO_DEF,
  parameter int unsigned EXT_HI       = EXT_HI_DEF
) (
  input logic                    clock,
  input logic                    ctrl_reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_cnt_next;

  logic              r_rf_we;
  logic [REG_W-1:0]  r_rf_reg;
  logic [DATA_W-1:0] r_rf_data;
  logic              r_wb_stall;
  logic              r_ext_ready;
  logic              r_ext_err;

  logic              w_ext_accept;
  logic              w_ext_legal;
  logic              w_push;
  logic              w_pop;
  logic              w_wb_valid;
  logic              w_wb_grant;
  wr_req_t           w_push_entry;
  wr_req_t           w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_full_next;

  assign w_ext_accept = bus.ext_valid && r_ext_ready;
  assign w_ext_legal  = in_window(bus.ext_reg, EXT_LO, EXT_HI);
  assign w_push       = w_ext_accept && w_ext_legal && !w_fifo_full;
  assign w_wb_valid   = bus.wb_we && (bus.wb_reg != '0);
  assign w_push_entry = '{idx: bus.ext_reg, data: bus.ext_data};

  wr_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_req_fifo (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .i_push        (w_push),
    .i_entry       (w_push_entry),
    .i_pop         (w_pop),
    .o_head_c      (w_head),
    .o_full        (w_fifo_full),
    .o_empty       (w_fifo_empty),
    .o_full_next_c (w_full_next)
  );

  // State register together with the starvation counter.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  // A queued write blocked for STARVE_LIMIT cycles forces one FORCE_EXT cycle.
  always_comb begin
    w_state_next      = r_state;
    w_starve_cnt_next = '0;
    case (r_state)
      NORMAL: begin
        if (!w_fifo_empty && !w_pop) begin
          if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            w_state_next = FORCE_EXT;
          end else begin
            w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
          end
        end
      end
      FORCE_EXT: w_state_next = NORMAL;
      default:   w_state_next = NORMAL;
    endcase
  end

  // Grant selection; writeback is ignored while the pipeline is held.
  always_comb begin
    w_wb_grant = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      NORMAL: begin
        w_wb_grant = w_wb_valid;
        w_pop      = !w_wb_valid && !w_fifo_empty;
      end
      FORCE_EXT: w_pop = !w_fifo_empty;
      default: begin
        w_wb_grant = 1'b0;
        w_pop      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_rf_we     <= 1'b0;
      r_rf_reg    <= '0;
      r_rf_data   <= '0;
      r_wb_stall  <= 1'b0;
      r_ext_ready <= 1'b0;
      r_ext_err   <= 1'b0;
    end else begin
      r_rf_we <= w_wb_grant || w_pop;
      if (w_wb_grant) begin
        r_rf_reg  <= bus.wb_reg;
        r_rf_data <= bus.wb_data;
      end else if (w_pop) begin
        r_rf_reg  <= w_head.idx;
        r_rf_data <= w_head.data;
      end
      r_wb_stall  <= (w_state_next == FORCE_EXT);
      r_ext_ready <= !w_full_next;
      r_ext_err   <= w_ext_accept && !w_ext_legal;
    end
  end

  assign bus.rf_we     = r_rf_we;
  assign bus.rf_reg    = r_rf_reg;
  assign bus.rf_data   = r_rf_data;
  assign bus.wb_stall  = r_wb_stall;
  assign bus.ext_ready = r_ext_ready;
  assign bus.ext_err   = r_ext_err;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table of per-cycle inputs and
// expected registered outputs, plus hand sequences for starvation and mid-run reset.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic clock      = 1'b0;
  logic ctrl_reset = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (8),
    .EXT_LO       (26),
    .EXT_HI       (29)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ext_valid;
    logic [4:0]  ext_reg;
    logic [31:0] ext_data;
    logic        rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    logic        stall;
    logic        ready;
    logic        err;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic a_we, input logic [4:0] a_reg, input logic [31:0] a_data,
                              input logic e_v, input logic [4:0] e_reg, input logic [31:0] e_data,
                              input logic x_we, input logic [4:0] x_reg, input logic [31:0] x_data,
                              input logic x_stall, input logic x_ready, input logic x_err);
    vec_t v;
    v.wb_we = a_we;   v.wb_reg = a_reg;   v.wb_data = a_data;
    v.ext_valid = e_v; v.ext_reg = e_reg; v.ext_data = e_data;
    v.rf_we = x_we;   v.rf_reg = x_reg;   v.rf_data = x_data;
    v.stall = x_stall; v.ready = x_ready; v.err = x_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a_we, input logic [4:0] a_reg, input logic [31:0] a_data,
                       input logic e_v, input logic [4:0] e_reg, input logic [31:0] e_data);
    bus.wb_we = a_we;   bus.wb_reg = a_reg;   bus.wb_data = a_data;
    bus.ext_valid = e_v; bus.ext_reg = e_reg; bus.ext_data = e_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rf_we"},     32'(bus.rf_we),     32'd0);
    check({tag, " rf_reg"},    32'(bus.rf_reg),    32'd0);
    check({tag, " rf_data"},   bus.rf_data,        32'd0);
    check({tag, " wb_stall"},  32'(bus.wb_stall),  32'd0);
    check({tag, " ext_ready"}, 32'(bus.ext_ready), 32'd0);
    check({tag, " ext_err"},   32'(bus.ext_err),   32'd0);
  endtask

  initial begin
    int stall_seen;

    //               wb_we  reg    data           ext_v  reg     data           rf_we reg    data           stall ready err
    vecs[0]  = mk(1'b1, 5'd5,  32'h0000_00A5, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h0000_00A5, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  32'h0000_00A5, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd27, 32'h0000_1234, 1'b0, 5'd5,  32'h0000_00A5, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd27, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd27, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h0000_DEAD, 1'b0, 5'd27, 32'h0000_1234, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd27, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 5'd0,  32'h0000_FFFF, 1'b1, 5'd26, 32'h0000_0026, 1'b0, 5'd27, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd26, 32'h0000_0026, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 5'd28, 32'h0000_0111, 1'b1, 5'd28, 32'h0000_0222, 1'b1, 5'd28, 32'h0000_0111, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd28, 32'h0000_0222, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd28, 32'h0000_0222, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 5'd3,  32'h0000_0030, 1'b1, 5'd27, 32'h0000_00A1, 1'b1, 5'd3,  32'h0000_0030, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 5'd3,  32'h0000_0031, 1'b1, 5'd28, 32'h0000_00A2, 1'b1, 5'd3,  32'h0000_0031, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 5'd3,  32'h0000_0032, 1'b1, 5'd29, 32'h0000_00A3, 1'b1, 5'd3,  32'h0000_0032, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd29, 32'h0000_00A3, 1'b1, 5'd27, 32'h0000_00A1, 1'b0, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd29, 32'h0000_00A3, 1'b1, 5'd28, 32'h0000_00A2, 1'b0, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd29, 32'h0000_00A3, 1'b0, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd29, 32'h0000_00A3, 1'b0, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 32'h0000_0BAD, 1'b0, 5'd29, 32'h0000_00A3, 1'b0, 1'b1, 1'b1);
    vecs[20] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd29, 32'h0000_00A3, 1'b0, 1'b1, 1'b0);

    // Power-on reset, then ready must rise on the first edge after release.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    step();
    check_reset_outputs("por");
    ctrl_reset = 1'b1;
    #1;
    check("release ready_before_edge", 32'(bus.ext_ready), 32'd0);
    step();
    check("release ready_after_edge", 32'(bus.ext_ready), 32'd1);
    check("release rf_we", 32'(bus.rf_we), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].wb_we, vecs[i].wb_reg, vecs[i].wb_data,
            vecs[i].ext_valid, vecs[i].ext_reg, vecs[i].ext_data);
      step();
      check($sformatf("vec%0d rf_we", i),     32'(bus.rf_we),     32'(vecs[i].rf_we));
      check($sformatf("vec%0d rf_reg", i),    32'(bus.rf_reg),    32'(vecs[i].rf_reg));
      check($sformatf("vec%0d rf_data", i),   bus.rf_data,        vecs[i].rf_data);
      check($sformatf("vec%0d wb_stall", i),  32'(bus.wb_stall),  32'(vecs[i].stall));
      check($sformatf("vec%0d ext_ready", i), 32'(bus.ext_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d ext_err", i),   32'(bus.ext_err),   32'(vecs[i].err));
    end

    // Starvation: continuous writeback to r3 while one external write waits.
    stall_seen = 0;
    for (int k = 0; k <= 10; k++) begin
      drive(1'b1, 5'd3, 32'h0000_0300 + 32'(k), (k == 0), 5'd27, 32'h0000_5A5A);
      step();
      if (bus.wb_stall) stall_seen++;
      check($sformatf("starve%0d wb_stall", k), 32'(bus.wb_stall), 32'(k == 8));
      check($sformatf("starve%0d rf_we", k), 32'(bus.rf_we), 32'd1);
      if (k == 9) begin
        check("starve9 rf_reg", 32'(bus.rf_reg), 32'd27);
        check("starve9 rf_data", bus.rf_data, 32'h0000_5A5A);
      end else begin
        check($sformatf("starve%0d rf_reg", k), 32'(bus.rf_reg), 32'd3);
        check($sformatf("starve%0d rf_data", k), bus.rf_data, 32'h0000_0300 + 32'(k));
      end
    end
    check("starve stall_cycles", 32'(stall_seen), 32'd1);

    // Reset with two queued entries must drop them without any regfile write.
    drive(1'b1, 5'd4, 32'h0000_0400, 1'b1, 5'd27, 32'h0000_00B1);
    step();
    drive(1'b1, 5'd4, 32'h0000_0401, 1'b1, 5'd28, 32'h0000_00B2);
    step();
    check("prereset ext_ready", 32'(bus.ext_ready), 32'd0);
    ctrl_reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check_reset_outputs("midreset_async");
    step();
    step();
    check_reset_outputs("midreset_held");
    ctrl_reset = 1'b1;
    step();
    check("postreset ext_ready", 32'(bus.ext_ready), 32'd1);
    check("postreset rf_we0", 32'(bus.rf_we), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("postreset rf_we%0d", k), 32'(bus.rf_we), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
